// File: rtl/path_probe_pkg.sv
// Shared types and helpers for the path probe sequencer.
package path_probe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int unsigned MAX_CNT_W = 32;

   // All-ones "no failure seen" marker, truncated by the caller to its count width.
   function automatic logic [MAX_CNT_W-1:0] fail_sentinel(input int unsigned width);
      logic [MAX_CNT_W-1:0] s;
      s = '0;
      for (int unsigned i = 0; i < MAX_CNT_W; i++) begin
         if (i < width) s[i] = 1'b1;
      end
      return s;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/path_probe_ctrl.sv
// Launch/settle/sample sequencer for the spy delay path, counting mismatching trials
// and driving the trojan trigger inputs while a run is armed.
module path_probe_ctrl
   import path_probe_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned WAIT_W = 8,
   parameter bit          INVERT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  trials,
   input  logic [WAIT_W-1:0] settle_cycles,
   input  logic              arm_ht,
   input  logic              path_out,
   output logic              path_in,
   output logic              ht_in1,
   output logic              ht_in2,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  first_fail,
   output logic              pass
);

   localparam logic [CNT_W-1:0] FAIL_NONE = CNT_W'(fail_sentinel(CNT_W));

   state_t            state, state_next;
   logic [CNT_W-1:0]  trials_q, idx_q, idx_inc_c;
   logic [WAIT_W-1:0] settle_q, wait_q;
   logic              arm_q, arm_c, ht_c;
   logic              capture_c, launch_c, settle_c, sample_c, done_c, mismatch_c;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next state and per-state strobes; abort overrides everything outside IDLE.
   always_comb begin
      state_next = state;
      capture_c  = 1'b0;
      launch_c   = 1'b0;
      settle_c   = 1'b0;
      sample_c   = 1'b0;
      done_c     = 1'b0;
      idx_inc_c  = idx_q + CNT_W'(1);
      mismatch_c = path_out != (path_in ^ INVERT);
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               capture_c  = 1'b1;
               state_next = (trials == '0) ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            launch_c   = 1'b1;
            state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            settle_c = 1'b1;
            if (wait_q == WAIT_W'(1)) state_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            sample_c   = 1'b1;
            state_next = (idx_inc_c == trials_q) ? ST_DONE : ST_LAUNCH;
         end
         ST_DONE: begin
            done_c     = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE)) begin
         state_next = ST_IDLE;
         launch_c   = 1'b0;
         settle_c   = 1'b0;
         sample_c   = 1'b0;
         done_c     = 1'b0;
      end
      arm_c = (state == ST_IDLE) ? arm_ht : arm_q;
      ht_c  = arm_c && (state_next inside {ST_LAUNCH, ST_SETTLE, ST_SAMPLE});
   end

   // Captured settings, trial/wait counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         trials_q   <= '0;
         settle_q   <= '0;
         arm_q      <= 1'b0;
         idx_q      <= '0;
         wait_q     <= '0;
         path_in    <= 1'b0;
         ht_in1     <= 1'b0;
         ht_in2     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         first_fail <= FAIL_NONE;
         pass       <= 1'b1;
      end else begin
         done   <= done_c;
         busy   <= (state_next != ST_IDLE) | done_c;
         ht_in1 <= ht_c;
         ht_in2 <= ht_c;
         if (capture_c) begin
            trials_q   <= trials;
            settle_q   <= settle_cycles;
            arm_q      <= arm_ht;
            idx_q      <= '0;
            first_fail <= FAIL_NONE;
         end
         if (launch_c) begin
            path_in <= ~path_in;
            wait_q  <= (settle_q == '0) ? WAIT_W'(1) : settle_q;
         end
         if (settle_c) wait_q <= wait_q - WAIT_W'(1);
         if (sample_c) begin
            idx_q <= idx_inc_c;
            if (mismatch_c && (first_fail == FAIL_NONE)) first_fail <= idx_q;
         end
         if (done_c) pass <= (err_count == '0);
      end
   end

   sat_counter #(.W(CNT_W)) u_err_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (capture_c),
      .inc   (sample_c & mismatch_c),
      .count (err_count)
   );

endmodule
